// File: rtl/apb_timer_pkg.sv
// Shared register offsets, bit positions and the byte-lane merge helper
// for the APB timer completer.
package apb_timer_pkg;

    localparam logic [4:0] OFS_CTRL   = 5'h00;
    localparam logic [4:0] OFS_PRESC  = 5'h04;
    localparam logic [4:0] OFS_COUNT  = 5'h08;
    localparam logic [4:0] OFS_CMP    = 5'h0C;
    localparam logic [4:0] OFS_STATUS = 5'h10;

    localparam int EN          = 0;
    localparam int AUTO_RELOAD = 1;
    localparam int IRQ_EN      = 2;
    localparam int MATCH       = 0;

    function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/apb_timer_slave_wait.sv
// Access-phase wait-state counter: holds PREADY low for WAIT_STATES cycles
// and flags the completing cycle.
module apb_slave_wait #(
    parameter int WAIT_STATES = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic psel,
    input  logic penable,
    output logic pready,
    output logic xfer_done
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    logic [3:0] wcnt_q, wcnt_d;

    // Gated by rst so a zero-wait completer cannot show PREADY while in reset.
    assign pready    = psel & penable & ~rst & (wcnt_q == WS);
    assign xfer_done = pready;

    always_comb begin
        wcnt_d = wcnt_q;
        if (!psel || pready) begin
            wcnt_d = '0;
        end else if (penable && (wcnt_q < WS)) begin
            wcnt_d = wcnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wcnt_q <= '0;
        else     wcnt_q <= wcnt_d;
    end

endmodule

// File: rtl/apb_timer_slave.sv
// APB completer hosting a prescaled 32-bit timer with compare match,
// auto-reload and a level interrupt.
module apb_timer_slave
    import apb_timer_pkg::*;
#(
    parameter int WAIT_STATES = 0,
    parameter int PRESC_W     = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic [31:0] PADDR,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    input  logic [3:0]  PSTRB,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        IRQ
);

    logic               xfer_done;
    logic [4:0]         ofs;
    logic               addr_err;
    logic               wr;
    logic [31:0]        rdata;

    logic [2:0]         ctrl_q,  ctrl_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] pcnt_q,  pcnt_d;
    logic [31:0]        count_q, count_d;
    logic [31:0]        cmp_q,   cmp_d;
    logic               match_q, match_d;

    logic               tick, hit;
    logic [31:0]        ctrl_m, presc_m, count_m, cmp_m;
    logic               unused_bits;

    apb_slave_wait #(.WAIT_STATES(WAIT_STATES)) u_wait (
        .clk       (PCLK),
        .rst       (PRESET),
        .psel      (PSEL),
        .penable   (PENABLE),
        .pready    (PREADY),
        .xfer_done (xfer_done)
    );

    assign ofs      = PADDR[4:0];
    assign addr_err = (ofs[1:0] != 2'b00) || (ofs > OFS_STATUS);
    assign wr       = xfer_done & PWRITE & ~addr_err;

    assign tick = ctrl_q[EN] & (pcnt_q == presc_q);
    assign hit  = tick & (count_q == cmp_q);

    assign ctrl_m  = strb_merge(32'(ctrl_q),  PWDATA, PSTRB);
    assign presc_m = strb_merge(32'(presc_q), PWDATA, PSTRB);
    assign count_m = strb_merge(count_q,      PWDATA, PSTRB);
    assign cmp_m   = strb_merge(cmp_q,        PWDATA, PSTRB);

    assign unused_bits = ^{PADDR[31:5], ctrl_m[31:3]};

    always_comb begin
        ctrl_d  = ctrl_q;
        presc_d = presc_q;
        pcnt_d  = pcnt_q;
        count_d = count_q;
        cmp_d   = cmp_q;
        match_d = match_q;

        // Timer advance first so that a same-cycle APB write overrides it.
        if (ctrl_q[EN]) pcnt_d = tick ? '0 : pcnt_q + PRESC_W'(1);
        if (tick) count_d = (hit && ctrl_q[AUTO_RELOAD]) ? '0 : count_q + 32'd1;

        if (wr) begin
            case (ofs)
                OFS_CTRL:  ctrl_d = ctrl_m[2:0];
                OFS_PRESC: begin
                    presc_d = PRESC_W'(presc_m);
                    pcnt_d  = '0;
                end
                OFS_COUNT: count_d = count_m;
                OFS_CMP:   cmp_d   = cmp_m;
                OFS_STATUS: if (PSTRB[0] && PWDATA[MATCH]) match_d = 1'b0;
                default: ;
            endcase
        end

        if (hit) match_d = 1'b1;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ctrl_q  <= '0;
            presc_q <= '0;
            pcnt_q  <= '0;
            count_q <= '0;
            cmp_q   <= '0;
            match_q <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
            count_q <= count_d;
            cmp_q   <= cmp_d;
            match_q <= match_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (ofs)
            OFS_CTRL:   rdata = 32'(ctrl_q);
            OFS_PRESC:  rdata = 32'(presc_q);
            OFS_COUNT:  rdata = count_q;
            OFS_CMP:    rdata = cmp_q;
            OFS_STATUS: rdata = 32'(match_q);
            default:    rdata = '0;
        endcase
    end

    assign PRDATA  = (PREADY && !addr_err) ? rdata : '0;
    assign PSLVERR = PREADY & addr_err;
    assign IRQ     = match_q & ctrl_q[IRQ_EN];

endmodule

// File: tb/tb_apb_timer_slave.sv
// Randomized APB bench for apb_timer_slave against a cycle-level behavioural
// model of the register map and timer.
module tb_apb_timer_slave;

    localparam int WS = 2;
    localparam int PW = 16;

    logic        PCLK = 1'b0;
    logic        PRESET, PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic [3:0]  PSTRB;
    logic        PREADY, PSLVERR, IRQ;

    int n_chk = 0;
    int n_err = 0;

    logic [2:0]    m_ctrl;
    logic [PW-1:0] m_presc, m_pcnt;
    logic [31:0]   m_count, m_cmp;
    logic          m_match;

    apb_timer_slave #(.WAIT_STATES(WS), .PRESC_W(PW)) u_dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .IRQ(IRQ)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_err(input logic [4:0] a);
        return (a[1:0] != 2'b00) || (a > 5'h10);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'h00:   return {29'b0, m_ctrl};
            5'h04:   return {16'b0, m_presc};
            5'h08:   return m_count;
            5'h0C:   return m_cmp;
            5'h10:   return {31'b0, m_match};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~mask) | (n & mask);
    endfunction

    task automatic model_reset();
        m_ctrl = '0; m_presc = '0; m_pcnt = '0;
        m_count = '0; m_cmp = '0; m_match = 1'b0;
    endtask

    // One rising edge of the reference: timer progress, then any committed write.
    task automatic model_edge(input bit w, input logic [4:0] a, input logic [31:0] d,
                              input logic [3:0] s);
        bit tk, hit;
        logic [31:0] t;
        tk  = m_ctrl[0] && (m_pcnt == m_presc);
        hit = tk && (m_count == m_cmp);
        if (m_ctrl[0]) m_pcnt = tk ? '0 : m_pcnt + 1'b1;
        if (tk) m_count = (hit && m_ctrl[1]) ? 32'h0 : m_count + 32'd1;
        if (w && !is_err(a)) begin
            case (a)
                5'h00: begin t = merge({29'b0, m_ctrl}, d, s); m_ctrl = t[2:0]; end
                5'h04: begin t = merge({16'b0, m_presc}, d, s); m_presc = t[PW-1:0]; m_pcnt = '0; end
                5'h08: m_count = merge(m_count, d, s);
                5'h0C: m_cmp = merge(m_cmp, d, s);
                5'h10: if (s[0] && d[0]) m_match = 1'b0;
                default: ;
            endcase
        end
        if (hit) m_match = 1'b1;
    endtask

    task automatic step(input bit w, input logic [4:0] a, input logic [31:0] d,
                        input logic [3:0] s);
        chk("irq", {31'b0, IRQ}, {31'b0, m_match & m_ctrl[2]});
        @(posedge PCLK);
        model_edge(w, a, d, s);
        #1;
    endtask

    task automatic idle(input int n);
        PSEL = 1'b0; PENABLE = 1'b0;
        repeat (n) step(1'b0, 5'h0, 32'h0, 4'h0);
    endtask

    task automatic apb(input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
        logic [4:0] o;
        bit e;
        o = a[4:0];
        e = is_err(o);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d; PSTRB = s;
        #1 chk("setup_pready", {31'b0, PREADY}, 32'h0);
        step(1'b0, o, d, s);
        PENABLE = 1'b1;
        for (int k = 0; k <= WS; k++) begin
            #1;
            chk("pready", {31'b0, PREADY}, (k == WS) ? 32'h1 : 32'h0);
            if (k == WS) begin
                chk("pslverr", {31'b0, PSLVERR}, {31'b0, e});
                if (!wr) chk("prdata", PRDATA, e ? 32'h0 : m_read(o));
            end else begin
                chk("wait_pslverr", {31'b0, PSLVERR}, 32'h0);
                chk("wait_prdata", PRDATA, 32'h0);
            end
            step((k == WS) && wr, o, d, s);
        end
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin
        logic [31:0] a, d;
        logic [4:0]  o;
        int          r;

        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; PSTRB = '0;
        model_reset();
        #1;
        chk("rst_pready", {31'b0, PREADY}, 32'h0);
        chk("rst_pslverr", {31'b0, PSLVERR}, 32'h0);
        chk("rst_prdata", PRDATA, 32'h0);
        chk("rst_irq", {31'b0, IRQ}, 32'h0);
        repeat (2) @(posedge PCLK);
        #1 PRESET = 1'b0;
        idle(2);

        // Partial-lane write, decode errors
        apb(1, 32'h08, 32'hAABBCCDD, 4'h3);
        apb(0, 32'h08, 32'h0, 4'h0);
        apb(0, 32'h14, 32'h0, 4'h0);
        apb(1, 32'h09, 32'h12345678, 4'hF);
        apb(0, 32'h08, 32'h0, 4'h0);
        apb(1, 32'h0C, 32'h00C0FFEE, 4'hF);

        // PSEL dropped mid-access, then reissued: waits restart from zero
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h0C;
        #1 step(1'b0, 5'h0, 32'h0, 4'h0);
        PENABLE = 1'b1;
        #1 chk("abort_pready", {31'b0, PREADY}, 32'h0);
        step(1'b0, 5'h0, 32'h0, 4'h0);
        idle(1);
        apb(0, 32'h0C, 32'h0, 4'h0);

        // CTRL writable bits
        apb(1, 32'h00, 32'h5, 4'hF);
        apb(0, 32'h00, 32'h0, 4'h0);
        apb(1, 32'h00, 32'hFFFFFFFF, 4'hF);
        apb(0, 32'h00, 32'h0, 4'h0);
        apb(1, 32'h00, 32'h0, 4'hF);

        // Prescaled counting up to a compare match with auto-reload
        apb(1, 32'h04, 32'h2, 4'hF);
        apb(1, 32'h0C, 32'h4, 4'hF);
        apb(1, 32'h08, 32'h0, 4'hF);
        apb(1, 32'h10, 32'h1, 4'h1);
        apb(1, 32'h00, 32'h7, 4'hF);
        idle(20);
        apb(0, 32'h08, 32'h0, 4'h0);
        apb(0, 32'h10, 32'h0, 4'h0);
        apb(1, 32'h10, 32'h1, 4'h1);
        apb(0, 32'h10, 32'h0, 4'h0);

        // Wrap without match
        apb(1, 32'h00, 32'h0, 4'hF);
        apb(1, 32'h10, 32'h1, 4'h1);
        apb(1, 32'h04, 32'h0, 4'hF);
        apb(1, 32'h0C, 32'h10, 4'hF);
        apb(1, 32'h08, 32'hFFFFFFFF, 4'hF);
        apb(1, 32'h00, 32'h1, 4'hF);
        idle(3);
        apb(0, 32'h08, 32'h0, 4'h0);
        apb(0, 32'h10, 32'h0, 4'h0);

        // COUNT write on a tick cycle; W1C against a continuous match
        apb(1, 32'h08, 32'h100, 4'hF);
        apb(0, 32'h08, 32'h0, 4'h0);
        apb(1, 32'h0C, 32'h0, 4'hF);
        apb(1, 32'h08, 32'h0, 4'hF);
        apb(1, 32'h00, 32'h3, 4'hF);
        apb(1, 32'h10, 32'h1, 4'hF);
        apb(0, 32'h10, 32'h0, 4'h0);
        apb(0, 32'h08, 32'h0, 4'h0);

        // Randomized traffic
        repeat (150) begin
            r = $urandom_range(0, 7);
            if (r <= 4)      o = 5'(r * 4);
            else if (r == 5) o = 5'(5'h14 + 4 * $urandom_range(0, 2));
            else             o = 5'($urandom_range(0, 31));
            a = ($urandom & 32'hFFFFFFE0) | {27'b0, o};
            if (o == 5'h04)      d = 32'($urandom_range(0, 3));
            else if (o == 5'h0C) d = m_count + 32'($urandom_range(0, 6));
            else                 d = $urandom;
            apb(1'($urandom_range(0, 1)), a, d, 4'($urandom_range(0, 15)));
            idle($urandom_range(0, 2));
        end

        // Asynchronous reset in the completing access cycle, with IRQ high
        apb(1, 32'h0C, 32'h0, 4'hF);
        apb(1, 32'h08, 32'h0, 4'hF);
        apb(1, 32'h04, 32'h0, 4'hF);
        apb(1, 32'h00, 32'h7, 4'hF);
        idle(2);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h00;
        #1 step(1'b0, 5'h0, 32'h0, 4'h0);
        PENABLE = 1'b1;
        repeat (WS) step(1'b0, 5'h0, 32'h0, 4'h0);
        #1;
        chk("pre_rst_pready", {31'b0, PREADY}, 32'h1);
        chk("pre_rst_prdata", PRDATA, m_read(5'h00));
        chk("pre_rst_irq", {31'b0, IRQ}, {31'b0, m_match & m_ctrl[2]});
        PRESET = 1'b1;
        #1;
        chk("arst_pready", {31'b0, PREADY}, 32'h0);
        chk("arst_prdata", PRDATA, 32'h0);
        chk("arst_pslverr", {31'b0, PSLVERR}, 32'h0);
        chk("arst_irq", {31'b0, IRQ}, 32'h0);
        @(posedge PCLK);
        model_reset();
        #1 PRESET = 1'b0;
        PSEL = 1'b0; PENABLE = 1'b0;
        idle(1);
        apb(0, 32'h00, 32'h0, 4'h0);
        apb(0, 32'h08, 32'h0, 4'h0);
        apb(0, 32'h0C, 32'h0, 4'h0);
        apb(0, 32'h10, 32'h0, 4'h0);
        apb(1, 32'h0C, 32'h0BADF00D, 4'hF);
        apb(0, 32'h0C, 32'h0, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
